// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: handshake/data bundle between a FIFO and its producer/consumer
//   master: drives flush, wr, rd, data_in; observes data_out, status flags, count, error pulses
//   slave : the FIFO side, with the opposite directions
interface fifo_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              flush;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    modport master (
        output flush, wr, rd, data_in,
        input  data_out, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  flush, wr, rd, data_in,
        output data_out, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with thresholds, count, error pulses, flush and FWFT mode
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of fifo_sync_param_if (flush/wr/rd/data_in in; data_out/flags/count/overflow/underflow out)
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dout_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              empty;
    logic              full;
    assign empty  = cnt == '0;
    assign full   = cnt == CNT_W'(DEPTH);
    assign rd_acc = bus.rd && !empty;
    // a read in the same cycle frees a slot, so a write into a full FIFO still lands
    assign wr_acc = bus.wr && (!full || rd_acc);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            dout_q <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr];
            end
            cnt   <= (wr_acc && !rd_acc) ? cnt + 1'b1 : (rd_acc && !wr_acc) ? cnt - 1'b1 : cnt;
            ovf_q <= bus.wr && !wr_acc;
            udf_q <= bus.rd && !rd_acc;
        end
    end
    // storage is never cleared; only writes that survive reset/flush priority land
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && wr_acc)
            mem[wr_ptr] <= bus.data_in;
    end
    assign bus.data_out     = FWFT ? (empty ? '0 : mem[rd_ptr]) : dout_q;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = cnt >= CNT_W'(AF_THRESH);
    assign bus.almost_empty = cnt <= CNT_W'(AE_THRESH);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param (depth 16, depth 12, FWFT)
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) f0 ();
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(12)) f1 ();
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) f2 ();
    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(f0));
    fifo_sync_param #(.DATA_W(8), .DEPTH(12), .FWFT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(f2));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        rst_n = 1'b0;
        {f0.flush, f0.wr, f0.rd, f0.data_in} = '0;
        {f1.flush, f1.wr, f1.rd, f1.data_in} = '0;
        {f2.flush, f2.wr, f2.rd, f2.data_in} = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_count", 32'(f0.count), 0);
        chk("rst_empty", 32'(f0.fifo_empty), 1);
        chk("rst_full", 32'(f0.fifo_full), 0);
        chk("rst_ae", 32'(f0.almost_empty), 1);
        chk("rst_af", 32'(f0.almost_full), 0);
        chk("rst_ovf", 32'(f0.overflow), 0);
        chk("rst_udf", 32'(f0.underflow), 0);
        chk("rst_dout", 32'(f0.data_out), 0);
        chk("rst_fwft_dout", 32'(f2.data_out), 0);
        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            f0.wr = 1'b1;
            f0.data_in = 8'(i);
            tick();
            chk("fill_count", 32'(f0.count), 32'(i));
            chk("fill_af", 32'(f0.almost_full), 32'(i >= 12));
            chk("fill_ae", 32'(f0.almost_empty), 32'(i <= 2));
        end
        chk("fill_full", 32'(f0.fifo_full), 1);
        // rejected write when full
        f0.data_in = 8'hAA;
        tick();
        f0.wr = 1'b0;
        chk("ovf_pulse", 32'(f0.overflow), 1);
        chk("ovf_count", 32'(f0.count), 16);
        tick();
        chk("ovf_clear", 32'(f0.overflow), 0);
        chk("ovf_count2", 32'(f0.count), 16);
        // drain in order
        for (int i = 1; i <= 16; i++) begin
            f0.rd = 1'b1;
            tick();
            chk("drain_dout", 32'(f0.data_out), 32'(i));
            chk("drain_count", 32'(f0.count), 32'(16 - i));
        end
        chk("drain_empty", 32'(f0.fifo_empty), 1);
        // underflow on empty
        tick();
        chk("udf1", 32'(f0.underflow), 1);
        chk("udf1_dout", 32'(f0.data_out), 32'h10);
        tick();
        chk("udf2", 32'(f0.underflow), 1);
        chk("udf2_count", 32'(f0.count), 0);
        chk("udf2_dout", 32'(f0.data_out), 32'h10);
        f0.wr = 1'b1;
        f0.data_in = 8'h55;
        tick();
        f0.wr = 1'b0;
        f0.rd = 1'b0;
        chk("wr_rd_empty_count", 32'(f0.count), 1);
        chk("wr_rd_empty_udf", 32'(f0.underflow), 1);
        tick();
        chk("udf_cleared", 32'(f0.underflow), 0);
        chk("hold_count", 32'(f0.count), 1);
        f0.rd = 1'b1;
        tick();
        f0.rd = 1'b0;
        chk("read_55", 32'(f0.data_out), 32'h55);
        chk("read_55_count", 32'(f0.count), 0);
        // full streaming, depth 16 and depth 12 side by side
        for (int i = 0; i < 16; i++) begin
            f0.wr = 1'b1;
            f0.data_in = 8'(i);
            f1.wr = (i < 12);
            f1.data_in = 8'(i);
            tick();
        end
        chk("stream_full16", 32'(f0.fifo_full), 1);
        chk("stream_full12", 32'(f1.fifo_full), 1);
        chk("stream_cnt12", 32'(f1.count), 12);
        for (int j = 0; j < 20; j++) begin
            f0.wr = 1'b1;
            f0.rd = 1'b1;
            f0.data_in = 8'(16 + j);
            f1.wr = 1'b1;
            f1.rd = 1'b1;
            f1.data_in = 8'(12 + j);
            tick();
            chk("s16_dout", 32'(f0.data_out), 32'(j));
            chk("s16_count", 32'(f0.count), 16);
            chk("s16_err", 32'({f0.overflow, f0.underflow}), 0);
            chk("s12_dout", 32'(f1.data_out), 32'(j));
            chk("s12_count", 32'(f1.count), 12);
            chk("s12_err", 32'({f1.overflow, f1.underflow}), 0);
        end
        f0.wr = 1'b0;
        f0.rd = 1'b0;
        f1.wr = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("s12_tail", 32'(f1.data_out), 32'(20 + j));
            chk("s12_tail_cnt", 32'(f1.count), 32'(11 - j));
        end
        f1.rd = 1'b0;
        // FWFT presentation
        f2.wr = 1'b1;
        f2.data_in = 8'h3C;
        tick();
        f2.wr = 1'b0;
        chk("fwft_show", 32'(f2.data_out), 32'h3C);
        chk("fwft_nempty", 32'(f2.fifo_empty), 0);
        tick();
        chk("fwft_hold", 32'(f2.data_out), 32'h3C);
        f2.rd = 1'b1;
        tick();
        f2.rd = 1'b0;
        chk("fwft_empty", 32'(f2.fifo_empty), 1);
        chk("fwft_zero", 32'(f2.data_out), 0);
        f2.wr = 1'b1;
        f2.data_in = 8'h11;
        tick();
        f2.data_in = 8'h22;
        tick();
        f2.wr = 1'b0;
        chk("fwft_head1", 32'(f2.data_out), 32'h11);
        f2.rd = 1'b1;
        tick();
        f2.rd = 1'b0;
        chk("fwft_head2", 32'(f2.data_out), 32'h22);
        // flush from count 9 (f0 holds 20..35)
        f0.rd = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("pre_flush_dout", 32'(f0.data_out), 32'(20 + j));
        end
        f0.rd = 1'b0;
        chk("pre_flush_count", 32'(f0.count), 9);
        f0.flush = 1'b1;
        tick();
        f0.flush = 1'b0;
        chk("flush_count", 32'(f0.count), 0);
        chk("flush_empty", 32'(f0.fifo_empty), 1);
        chk("flush_ae", 32'(f0.almost_empty), 1);
        chk("flush_dout_held", 32'(f0.data_out), 26);
        f2.flush = 1'b1;
        tick();
        f2.flush = 1'b0;
        chk("fwft_flush_dout", 32'(f2.data_out), 0);
        // reset while writing
        f0.wr = 1'b1;
        f0.data_in = 8'h77;
        tick();
        tick();
        tick();
        chk("pre_rst_count", 32'(f0.count), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        f0.wr = 1'b0;
        chk("rst_wr_count", 32'(f0.count), 0);
        chk("rst_wr_empty", 32'(f0.fifo_empty), 1);
        chk("rst_wr_dout", 32'(f0.data_out), 0);
        tick();
        chk("post_rst_count", 32'(f0.count), 0);
        f0.rd = 1'b1;
        tick();
        f0.rd = 1'b0;
        chk("post_rst_udf", 32'(f0.underflow), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO for the image-processing datapath. It generalises the 8-bit pixel FIFO to arbitrary data width and depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It buffers pixel or line data between producer and consumer stages running on the same clock.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of storage words (>=2; need not be a power of two)
AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (data one cycle after rd); 1 = head word presented without a rd
CNT_W, $clog2(DEPTH+1), width of count (derived; not to be overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset
flush  input  1  synchronous clear of contents; same effect as reset, except data_out is held
wr  input  1  write request
rd  input  1  read request
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  CNT_W  current occupancy
overflow  output  1  one-cycle pulse: previous cycle had a wr rejected
underflow  output  1  one-cycle pulse: previous cycle had a rd rejected

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk; single clock domain.
- Reset: wr_ptr=0, rd_ptr=0, count=0. Outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? n/a : 0), overflow=0, underflow=0, data_out=0. Memory contents are not cleared.
- Reset mid-operation discards all stored words. The first cycle after release behaves as an empty FIFO.
- Priority: rst_n low > flush > wr/rd.
- flush: clears pointers, count and error pulses like reset. data_out keeps its value when FWFT=0; it reads 0 when FWFT=1.
- Write accepted (wr_acc) when wr && (!fifo_full || rd_acc).
  - Effect: mem[wr_ptr] <= data_in; wr_ptr advances.
- Read accepted (rd_acc) when rd && !fifo_empty; rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0, for any DEPTH, not only powers of two.
- count next value: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- Simultaneous wr & rd when full: both accepted, count stays DEPTH, and no overflow.
- Simultaneous wr & rd when empty: the write is accepted and the read is rejected (underflow pulse). count becomes 1.
- All status flags are combinational decodes of the count register, so they change on the edge after the causing request. Latency is 1 cycle.
- overflow <= wr && !wr_acc; underflow <= rd && !rd_acc. Each is a registered pulse lasting one cycle per rejected request and is not sticky.
- FWFT=0:
  - data_out is a register. On rd_acc, data_out <= mem[rd_ptr] and is visible the cycle after rd.
  - It holds its value otherwise, including on a rejected read.
- FWFT=1:
  - data_out = fifo_empty ? 0 : mem[rd_ptr], combinationally.
  - rd acknowledges (pops) the presented word.
  - A word written into an empty FIFO appears on data_out the cycle after the write.
- Data ordering is strictly first-in, first-out. No word is ever duplicated or lost unless the loss is flagged by overflow.

Test Plan:
1. Defaults (DATA_W=8, DEPTH=16, FWFT=0). Reset, then write 0x01..0x10 on 16 consecutive cycles:
   - count reaches 16 and fifo_full=1.
   - almost_full rises the cycle after the 12th write.
   - almost_empty falls the cycle after the 3rd write.
2. From full, pulse wr with data_in=0xAA for 1 cycle: overflow=1 for exactly one cycle and count stays 16. Then read 16 times: data_out sequence is 0x01..0x10, each one cycle after its rd; 0xAA never appears.
3. Empty FIFO, rd=1 for 2 cycles: underflow high for 2 cycles, count=0, data_out unchanged. Then wr=1 and rd=1 together with data 0x55: count=1, underflow=1 for one cycle.
4. Full FIFO, wr=1 and rd=1 for 20 cycles with incrementing data:
   - count stays 16; no overflow or underflow.
   - Read stream continues in order across pointer wrap.
   - Repeat with DEPTH=12 (non-power-of-two wrap).
5. FWFT=1: write 0x3C into an empty FIFO; next cycle data_out=0x3C with rd=0. Pulse rd: the following cycle fifo_empty=1 and data_out=0.
6. With count=9, assert flush for 1 cycle: next cycle count=0, fifo_empty=1, almost_empty=1. Repeat with rst_n=0 for 1 cycle while wr=1: the write is ignored and count=0.
